// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: shifts an N-bit operand one bit position per clock
// by a variable amount (logical/arithmetic right, logical left, rotate right).
module shift_seq_ctrl #(
  parameter int N   = 8,
  parameter int SHW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [SHW-1:0] shamt,
  input  logic [1:0]     op,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   C,
  output logic [1:0]     o_dbg_state
);

  // Handshake: start is sampled only in IDLE; the accepting edge captures A/shamt/op.
  // done is a one-cycle registered pulse with C valid from that cycle; busy covers
  // SHIFT and DONE, during which start is ignored (no queuing).
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [N-1:0]   r_work;
  logic [N-1:0]   w_step;
  logic [SHW-1:0] r_count;
  logic [1:0]     r_op;
  logic [N-1:0]   r_c;

  always_comb begin
    w_next_state = r_state;
    w_step       = r_work;
    case (r_op)
      2'b00:   w_step = {1'b0, r_work[N-1:1]};
      2'b01:   w_step = {r_work[N-1], r_work[N-1:1]};
      2'b10:   w_step = {r_work[N-2:0], 1'b0};
      default: w_step = {r_work[0], r_work[N-1:1]};
    endcase
    case (r_state)
      S_IDLE:  if (start) w_next_state = (shamt == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (r_count == SHW'(1)) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_count <= '0;
      r_op    <= 2'b00;
      r_c     <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work  <= A;
            r_count <= shamt;
            r_op    <= op;
            // Zero shift completes straight from IDLE, so the result is the operand.
            if (shamt == '0) r_c <= A;
          end
        end
        S_SHIFT: begin
          r_work  <= w_step;
          r_count <= r_count - 1'b1;
          if (r_count == SHW'(1)) r_c <= w_step;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign C           = r_c;
  assign o_dbg_state = r_state;

endmodule
